fetch_prefetch: RTL and testbench



---
 rtl/fetch_prefetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_prefetch.sv | 125 ++++++++++++
 tb/tb_fetch_prefetch.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_pkg.sv
// Shared constants and width helpers for the prefetching fetch stage.
package fetch_prefetch_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instruction} pairs; flush beats push and pop.
module fetch_fifo
  import fetch_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * WORD_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the count alone decides which slots hold valid data.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: issues imem requests, buffers responses, feeds the D register,
// and drops responses belonging to a stream abandoned by a redirect.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int unsigned    WORD     = WORD_W,
  parameter int unsigned    DEPTH    = 4,
  parameter int unsigned    MAX_OUT  = 2,
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PCSrcM,
  input  logic [WORD-1:0] pcM,
  input  logic            stallD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [WORD-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [WORD-1:0] imem_resp_data,
  output logic [WORD-1:0] pcD,
  output logic [WORD-1:0] instrD,
  output logic            validD
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned IW = cnt_w(MAX_OUT);
  localparam int unsigned SW = cnt_w(MAX_OUT + DEPTH);

  logic [WORD-1:0] r_fetch_pc;
  logic [WORD-1:0] r_resp_pc;
  logic [IW-1:0]   r_inflight;
  logic [IW-1:0]   r_drop;
  logic [WORD-1:0] r_pc_d;
  logic [WORD-1:0] r_instr_d;
  logic            r_valid_d;

  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [2*WORD-1:0] w_fifo_dout;
  logic [SW-1:0]     w_reserved;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  // Every live request already owns a FIFO slot, so a push can never find it full.
  assign w_reserved     = SW'(r_inflight - r_drop) + SW'(w_fifo_count);
  assign imem_req_valid = !PCSrcM && (r_inflight < IW'(MAX_OUT)) && (w_reserved < SW'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign w_push         = imem_resp_valid && (r_drop == '0) && !PCSrcM;
  assign w_pop          = !PCSrcM && !stallD && !w_fifo_empty;

  fetch_fifo #(
    .WIDTH (2 * WORD),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (PCSrcM),
    .din   ({r_resp_pc, imem_resp_data}),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty),
    .full  (w_fifo_full),
    .count (w_fifo_count)
  );

  // r_resp_pc is the address of the next live response, so pcD needs no per-request tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else if (PCSrcM) begin
      r_fetch_pc <= pcM;
      r_resp_pc  <= pcM;
      r_inflight <= r_inflight - IW'(imem_resp_valid);
      r_drop     <= r_inflight - IW'(imem_resp_valid);
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + WORD'(4);
      if (w_push)   r_resp_pc  <= r_resp_pc + WORD'(4);
      r_inflight <= r_inflight + IW'(w_accept) - IW'(imem_resp_valid);
      if (imem_resp_valid && (r_drop != '0)) r_drop <= r_drop - IW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_d <= 1'b0;
      r_pc_d    <= '0;
      r_instr_d <= WORD'(NOP_INSTR);
    end else if (PCSrcM) begin
      r_valid_d <= 1'b0;
      r_instr_d <= WORD'(NOP_INSTR);
    end else if (!stallD) begin
      if (!w_fifo_empty) begin
        r_valid_d <= 1'b1;
        r_pc_d    <= w_fifo_dout[2*WORD-1:WORD];
        r_instr_d <= w_fifo_dout[WORD-1:0];
      end else begin
        r_valid_d <= 1'b0;
        r_instr_d <= WORD'(NOP_INSTR);
      end
    end
  end

  assign pcD    = r_pc_d;
  assign instrD = r_instr_d;
  assign validD = r_valid_d;

`ifndef SYNTHESIS
  a_resp_without_request: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> (r_inflight != '0));
  a_redirect_aligned: assert property (@(posedge clk) disable iff (reset)
    PCSrcM |-> (pcM[1:0] == 2'b00));
  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (w_push && w_fifo_full) |-> w_pop);
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: in-order imem model with random latency plus a
// stream-level reference (expected fetch/deliver PCs, memory contents as a function of address).
module tb_fetch_prefetch;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCSrcM = 1'b0;
  logic [31:0] pcM = '0;
  logic        stallD = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [31:0] pcD;
  logic [31:0] instrD;
  logic        validD;

  fetch_prefetch #(
    .WORD     (32),
    .DEPTH    (4),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (32'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .PCSrcM          (PCSrcM),
    .pcM             (pcM),
    .stallD          (stallD),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .pcD             (pcD),
    .instrD          (instrD),
    .validD          (validD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  req_t        q[$];
  int unsigned cyc = 0;
  int unsigned lat_extra = 0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_req_pc = '0;
  int          deliveries = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample the request/redirect side, advance, then check D and drive imem.
  task automatic tick();
    logic        acc;
    logic [31:0] acc_addr;
    logic        redir;
    logic [31:0] redir_pc;
    logic        stl;
    logic        pv;
    logic [31:0] ppc;
    logic [31:0] pins;
    #2;
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    redir    = PCSrcM;
    redir_pc = pcM;
    stl      = stallD;
    pv       = validD;
    ppc      = pcD;
    pins     = instrD;
    if (redir) check("req_valid_in_redirect", 64'(imem_req_valid), 64'(0));
    if (acc) begin
      check("req_addr", 64'(acc_addr), 64'(exp_req_pc));
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (redir) exp_req_pc = redir_pc;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) q.push_back('{addr: acc_addr, due: cyc + lat_extra});
    if (redir) begin
      check("redirect_validD", 64'(validD), 64'(0));
      check("redirect_instrD", 64'(instrD), 64'(NOP));
      exp_pc = redir_pc;
    end else if (stl) begin
      check("stall_hold_validD", 64'(validD), 64'(pv));
      check("stall_hold_pcD", 64'(pcD), 64'(ppc));
      check("stall_hold_instrD", 64'(instrD), 64'(pins));
    end else if (validD) begin
      check("deliver_pcD", 64'(pcD), 64'(exp_pc));
      check("deliver_instrD", 64'(instrD), 64'(mem_word(exp_pc)));
      exp_pc = exp_pc + 32'd4;
      deliveries++;
    end else begin
      check("bubble_instrD", 64'(instrD), 64'(NOP));
    end
    check("outstanding_bound", 64'(q.size() <= MAX_OUT), 64'(1));
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(q[0].addr);
      void'(q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    PCSrcM          = 1'b0;
    stallD          = 1'b0;
    imem_resp_valid = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    exp_pc     = '0;
    exp_req_pc = '0;
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    bit found = 0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      tick();
      if (validD) found = 1;
    end
    if (!found) check(tag, 64'(0), 64'(1));
  endtask

  initial begin
    int d0;
    bit hit;

    // Zero-wait imem: first delivery after the third edge, then one per cycle.
    imem_req_ready = 1'b1;
    lat_extra      = 0;
    do_reset();
    check("reset_validD", 64'(validD), 64'(0));
    check("reset_pcD", 64'(pcD), 64'(0));
    check("reset_instrD", 64'(instrD), 64'(NOP));
    tick(); check("t1_edge1_validD", 64'(validD), 64'(0));
    tick(); check("t1_edge2_validD", 64'(validD), 64'(0));
    tick(); check("t1_edge3_validD", 64'(validD), 64'(1));
    check("t1_pc0", 64'(pcD), 64'(32'h0));
    tick(); check("t1_pc4", 64'(pcD), 64'(32'h4));
    tick(); check("t1_pc8", 64'(pcD), 64'(32'h8));
    tick(); check("t1_pcC", 64'(pcD), 64'(32'hC));

    // Stall long enough to fill the FIFO; requests must stop.
    stallD = 1'b1;
    repeat (6) tick();
    check("t2_req_valid_full", 64'(imem_req_valid), 64'(0));
    stallD = 1'b0;
    tick();
    check("t2_release_validD", 64'(validD), 64'(1));
    repeat (4) tick();

    // Redirect with two slow requests in flight.
    lat_extra = 2;
    hit = 0;
    for (int i = 0; i < 12 && !hit; i++) begin
      tick();
      if (q.size() == 2) hit = 1;
    end
    check("t3_two_inflight", 64'(hit), 64'(1));
    PCSrcM = 1'b1; pcM = 32'h100;
    tick();
    PCSrcM = 1'b0;
    check("t3_validD_cleared", 64'(validD), 64'(0));
    wait_valid(40, "t3_timeout");
    check("t3_first_pc", 64'(pcD), 64'(32'h100));

    // Redirect coinciding with a response while decode is stalled.
    lat_extra = 0;
    stallD    = 1'b1;
    for (int i = 0; i < 10 && !imem_resp_valid; i++) tick();
    check("t4_resp_present", 64'(imem_resp_valid), 64'(1));
    PCSrcM = 1'b1; pcM = 32'h180;
    tick();
    PCSrcM = 1'b0;
    check("t4_validD_cleared", 64'(validD), 64'(0));
    stallD = 1'b0;
    wait_valid(40, "t4_timeout");
    check("t4_first_pc", 64'(pcD), 64'(32'h180));

    // Back-to-back redirects; nothing from the 0x200 stream may reach D.
    lat_extra = 1;
    PCSrcM = 1'b1; pcM = 32'h200;
    tick();
    PCSrcM = 1'b0;
    tick();
    PCSrcM = 1'b1; pcM = 32'h300;
    tick();
    PCSrcM = 1'b0;
    wait_valid(40, "t5_timeout");
    check("t5_first_pc", 64'(pcD), 64'(32'h300));

    // Asynchronous reset while the pipe is busy.
    lat_extra = 3;
    stallD    = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("t6_async_validD", 64'(validD), 64'(0));
    check("t6_async_pcD", 64'(pcD), 64'(0));
    check("t6_async_instrD", 64'(instrD), 64'(NOP));
    do_reset();
    lat_extra = 0;
    #2;
    check("t6_req_valid", 64'(imem_req_valid), 64'(1));
    check("t6_req_addr", 64'(imem_req_addr), 64'(32'h0));

    // Fetch PC wraps from the top of the address space.
    PCSrcM = 1'b1; pcM = 32'hFFFF_FFFC;
    tick();
    PCSrcM = 1'b0;
    check("t7_addr_top", 64'(imem_req_addr), 64'(32'hFFFF_FFFC));
    tick();
    check("t7_addr_wrap", 64'(imem_req_addr), 64'(32'h0));
    wait_valid(20, "t7_timeout");
    check("t7_pc_top", 64'(pcD), 64'(32'hFFFF_FFFC));
    tick();
    check("t7_pc_wrap", 64'(pcD), 64'(32'h0));

    // Random traffic: ready, latency, stalls and redirects all vary.
    for (int i = 0; i < 800; i++) begin
      stallD         = ($urandom_range(0, 3) == 0);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      lat_extra      = $urandom_range(0, 3);
      if ($urandom_range(0, 24) == 0) begin
        PCSrcM = 1'b1;
        pcM    = 32'($urandom_range(0, 1023)) << 2;
      end else begin
        PCSrcM = 1'b0;
      end
      tick();
    end

    // Quiet drain: the stream must keep flowing at close to one per cycle.
    PCSrcM         = 1'b0;
    stallD         = 1'b0;
    imem_req_ready = 1'b1;
    lat_extra      = 0;
    d0 = deliveries;
    repeat (30) tick();
    check("drain_progress", 64'((deliveries - d0) >= 20), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
